// File: rtl/svm_scheduler.sv
// svm_scheduler: sequences an SVM accelerator. It first streams MEM_ROWS
// weight rows from the host into the SVM SRAM, then repeatedly accepts one
// window of valence/arousal feature vectors, offers them to the SVM in order
// (valence first, then arousal), waits for the SVM result with a timeout and
// presents the registered result to a downstream consumer.
module svm_scheduler #(
  parameter int NBITS    = 9,
  parameter int F_WIDTH  = 214,
  parameter int MEM_ROWS = 144,
  parameter int TIMEOUT  = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_row_valid,
  output logic                       host_row_ready,
  input  logic                       host_intercept_valid,
  output logic [7:0]                 mem_write_addr,
  output logic                       mem_we,
  input  logic                       mem_write_ready,
  output logic                       mem_write_done,
  output logic                       intercept_valid,
  input  logic                       win_valid,
  output logic                       win_ready,
  input  logic [NBITS*F_WIDTH-1:0]   win_v_features,
  input  logic [NBITS*F_WIDTH-1:0]   win_a_features,
  output logic [NBITS*F_WIDTH-1:0]   svm_features,
  output logic                       svm_fin_valid,
  input  logic                       svm_fin_ready,
  input  logic                       svm_dout_valid,
  input  logic                       svm_valence,
  input  logic                       svm_arousal,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_valence,
  output logic                       res_arousal,
  output logic [15:0]                res_count,
  output logic                       err_timeout,
  output logic                       busy
);

  localparam int VW = NBITS * F_WIDTH;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [7:0]    LAST_ROW = 8'(MEM_ROWS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_LOAD      = 3'd0;
  localparam logic [2:0] S_LOAD_DONE = 3'd1;
  localparam logic [2:0] S_IDLE      = 3'd2;
  localparam logic [2:0] S_SEND_V    = 3'd3;
  localparam logic [2:0] S_SEND_A    = 3'd4;
  localparam logic [2:0] S_WAIT_RES  = 3'd5;
  localparam logic [2:0] S_OUT       = 3'd6;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [7:0]    row_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [VW-1:0] v_buf;
  logic [VW-1:0] a_buf;
  logic          sel_a;

  logic in_load;
  logic in_load_done;
  logic in_idle;
  logic in_send_v;
  logic in_send_a;
  logic in_wait;
  logic in_out;
  logic row_wr;
  logic last_row;
  logic tmo_hit;
  logic win_acc;
  logic v_hs;
  logic a_hs;
  logic res_hs;

  assign in_load      = (state == S_LOAD);
  assign in_load_done = (state == S_LOAD_DONE);
  assign in_idle      = (state == S_IDLE);
  assign in_send_v    = (state == S_SEND_V);
  assign in_send_a    = (state == S_SEND_A);
  assign in_wait      = (state == S_WAIT_RES);
  assign in_out       = (state == S_OUT);

  assign row_wr   = in_load & host_row_valid & mem_write_ready;
  assign last_row = (row_cnt == LAST_ROW);
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign win_acc  = in_idle & win_valid;
  assign v_hs     = in_send_v & svm_fin_ready;
  assign a_hs     = in_send_a & svm_fin_ready;
  assign res_hs   = in_out & res_ready;

  // Outputs that are pure functions of inputs while in LOAD are gated by rst,
  // because reset parks the FSM in LOAD and they would otherwise leak through.
  assign host_row_ready  = rst & in_load & mem_write_ready;
  assign mem_we          = rst & row_wr;
  assign intercept_valid = rst & (in_load | in_load_done) & host_intercept_valid;
  assign busy            = rst & ~in_idle;

  // Remaining outputs derive from state/registers that reset already clears.
  assign mem_write_addr = row_cnt;
  assign mem_write_done = in_load_done;
  assign win_ready      = in_idle;
  assign svm_fin_valid  = in_send_v | in_send_a;
  assign res_valid      = in_out;
  assign svm_features   = sel_a ? a_buf : v_buf;

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      S_LOAD:      if (row_wr && last_row) state_nx = S_LOAD_DONE;
      S_LOAD_DONE: state_nx = S_IDLE;
      S_IDLE:      if (win_valid) state_nx = S_SEND_V;
      S_SEND_V:    if (svm_fin_ready) state_nx = S_SEND_A;
      S_SEND_A:    if (svm_fin_ready) state_nx = S_WAIT_RES;
      S_WAIT_RES: begin
        // A result arriving on the limit cycle still counts as a result.
        if (svm_dout_valid)  state_nx = S_OUT;
        else if (tmo_hit)    state_nx = S_IDLE;
      end
      S_OUT:       if (res_ready) state_nx = S_IDLE;
      default:     state_nx = S_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) state <= S_LOAD;
    else      state <= state_nx;
  end

  // SRAM row counter; holds its value while mem_write_ready is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        row_cnt <= '0;
    else if (row_wr) row_cnt <= last_row ? 8'd0 : row_cnt + 8'd1;
  end

  // Result timeout counter, cleared when the arousal vector is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         tmo_cnt <= '0;
    else if (a_hs)    tmo_cnt <= '0;
    else if (in_wait) tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     err_timeout <= 1'b0;
    else if (in_wait && !svm_dout_valid && tmo_hit) err_timeout <= 1'b1;
  end

  // Window buffer, loaded once per accepted window.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: this wide buffer is reset on purpose so svm_features reads 0 after reset.
    if (!rst) begin
      v_buf <= '0;
      a_buf <= '0;
    end else if (win_acc) begin
      v_buf <= win_v_features;
      a_buf <= win_a_features;
    end
  end

  // Feature mux select: valence on entry to SEND_V, arousal on entry to SEND_A,
  // otherwise held so svm_features keeps the last offered vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         sel_a <= 1'b0;
    else if (win_acc) sel_a <= 1'b0;
    else if (v_hs)    sel_a <= 1'b1;
  end

  // Result capture from the SVM, only while waiting for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valence <= 1'b0;
      res_arousal <= 1'b0;
    end else if (in_wait && svm_dout_valid) begin
      res_valence <= svm_valence;
      res_arousal <= svm_arousal;
    end
  end

  // Count of results handed to the consumer, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        res_count <= '0;
    else if (res_hs) res_count <= res_count + 16'd1;
  end

endmodule

// File: tb/tb_svm_scheduler.sv
// tb_svm_scheduler: directed-sequence bench with randomized windows, SVM
// latencies, backpressure and result bits, checked against expectations
// computed from the scheduler's behavioural rules.
module tb_svm_scheduler;

  localparam int NB   = 9;
  localparam int FW   = 214;
  localparam int ROWS = 144;
  localparam int TMO  = 1024;
  localparam int VW   = NB * FW;

  typedef struct {
    logic [VW-1:0] v;
    logic [VW-1:0] a;
    int            sv;   // SEND_V stall cycles
    int            sa;   // SEND_A stall cycles
    int            lat;  // SVM latency in WAIT_RES cycles, -1 = never answers
    int            sr;   // OUT stall cycles
    logic          val;
    logic          aro;
  } win_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_row_valid;
  logic          host_row_ready;
  logic          host_intercept_valid;
  logic [7:0]    mem_write_addr;
  logic          mem_we;
  logic          mem_write_ready;
  logic          mem_write_done;
  logic          intercept_valid;
  logic          win_valid;
  logic          win_ready;
  logic [VW-1:0] win_v_features;
  logic [VW-1:0] win_a_features;
  logic [VW-1:0] svm_features;
  logic          svm_fin_valid;
  logic          svm_fin_ready;
  logic          svm_dout_valid;
  logic          svm_valence;
  logic          svm_arousal;
  logic          res_valid;
  logic          res_ready;
  logic          res_valence;
  logic          res_arousal;
  logic [15:0]   res_count;
  logic          err_timeout;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;
  logic exp_err = 1'b0;
  win_t wins[$];

  svm_scheduler #(.NBITS(NB), .F_WIDTH(FW), .MEM_ROWS(ROWS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .host_row_valid(host_row_valid), .host_row_ready(host_row_ready),
    .host_intercept_valid(host_intercept_valid),
    .mem_write_addr(mem_write_addr), .mem_we(mem_we),
    .mem_write_ready(mem_write_ready), .mem_write_done(mem_write_done),
    .intercept_valid(intercept_valid),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_v_features(win_v_features), .win_a_features(win_a_features),
    .svm_features(svm_features), .svm_fin_valid(svm_fin_valid),
    .svm_fin_ready(svm_fin_ready), .svm_dout_valid(svm_dout_valid),
    .svm_valence(svm_valence), .svm_arousal(svm_arousal),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_valence(res_valence), .res_arousal(res_arousal),
    .res_count(res_count), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed_lo=%h expected_lo=%h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < FW; i++) r[i*NB +: NB] = NB'($urandom);
    return r;
  endfunction

  function automatic logic [VW-1:0] fill_vec(input logic [NB-1:0] e);
    logic [VW-1:0] r;
    for (int i = 0; i < FW; i++) r[i*NB +: NB] = e;
    return r;
  endfunction

  // Drive one window through the scheduler while acting as the SVM and consumer.
  task automatic run_window(input win_t w);
    settle();
    check_bit("idle_win_ready", win_ready, 1'b1);
    check_bit("idle_busy", busy, 1'b0);
    check_bit("err_sticky", err_timeout, exp_err);
    win_valid = 1'b1; win_v_features = w.v; win_a_features = w.a;
    svm_dout_valid = 1'b1;  // ignored outside WAIT_RES
    settle();
    step();
    win_valid = 1'b0; win_v_features = rand_vec(); win_a_features = rand_vec();
    // SEND_V
    for (int i = 0; i < w.sv; i++) begin
      svm_fin_ready = 1'b0; svm_dout_valid = 1'($urandom);
      settle();
      check_bit("v_fin_valid", svm_fin_valid, 1'b1);
      check_vec("v_features", svm_features, w.v);
      check_bit("v_win_ready", win_ready, 1'b0);
      step();
    end
    svm_fin_ready = 1'b1; svm_dout_valid = 1'($urandom);
    settle();
    check_bit("v_fin_valid_hs", svm_fin_valid, 1'b1);
    check_vec("v_features_hs", svm_features, w.v);
    step();
    // SEND_A
    for (int i = 0; i < w.sa; i++) begin
      svm_fin_ready = 1'b0; svm_dout_valid = 1'($urandom);
      settle();
      check_bit("a_fin_valid", svm_fin_valid, 1'b1);
      check_vec("a_features", svm_features, w.a);
      check_bit("a_win_ready", win_ready, 1'b0);
      check_bit("a_res_valid", res_valid, 1'b0);
      step();
    end
    svm_fin_ready = 1'b1; svm_dout_valid = 1'($urandom);
    settle();
    check_bit("a_fin_valid_hs", svm_fin_valid, 1'b1);
    check_vec("a_features_hs", svm_features, w.a);
    step();
    svm_fin_ready = 1'b0; svm_dout_valid = 1'b0;
    if (w.lat < 0) begin
      // No answer: TMO waiting cycles, then back to IDLE with the error flag.
      for (int i = 0; i < TMO; i++) begin
        settle();
        check_bit("tmo_busy", busy, 1'b1);
        check_bit("tmo_err_early", err_timeout, exp_err);
        check_bit("tmo_res_valid", res_valid, 1'b0);
        step();
      end
      exp_err = 1'b1;
      settle();
      check_bit("tmo_err", err_timeout, 1'b1);
      check_bit("tmo_idle", busy, 1'b0);
      check_bit("tmo_win_ready", win_ready, 1'b1);
      check_bit("tmo_no_result", res_valid, 1'b0);
      check_val("tmo_count", 64'(res_count), 64'(exp_count));
      check_vec("tmo_features_held", svm_features, w.a);
      return;
    end
    // WAIT_RES
    for (int i = 0; i < w.lat; i++) begin
      settle();
      check_bit("w_fin_valid", svm_fin_valid, 1'b0);
      check_bit("w_res_valid", res_valid, 1'b0);
      check_bit("w_busy", busy, 1'b1);
      check_vec("w_features_held", svm_features, w.a);
      step();
    end
    svm_dout_valid = 1'b1; svm_valence = w.val; svm_arousal = w.aro;
    settle();
    check_bit("w_res_valid_last", res_valid, 1'b0);
    step();
    svm_dout_valid = 1'b0; svm_valence = ~w.val; svm_arousal = ~w.aro;
    // OUT
    for (int i = 0; i < w.sr; i++) begin
      res_ready = 1'b0;
      svm_dout_valid = 1'($urandom); svm_valence = 1'($urandom); svm_arousal = 1'($urandom);
      settle();
      check_bit("o_res_valid", res_valid, 1'b1);
      check_bit("o_valence", res_valence, w.val);
      check_bit("o_arousal", res_arousal, w.aro);
      check_bit("o_win_ready", win_ready, 1'b0);
      check_val("o_count_before", 64'(res_count), 64'(exp_count));
      step();
    end
    res_ready = 1'b1; svm_dout_valid = 1'b0;
    settle();
    check_bit("o_res_valid_hs", res_valid, 1'b1);
    check_bit("o_valence_hs", res_valence, w.val);
    check_bit("o_arousal_hs", res_arousal, w.aro);
    step();
    res_ready = 1'b0;
    exp_count = (exp_count + 1) % 65536;
    settle();
    check_val("res_count", 64'(res_count), 64'(exp_count));
    check_bit("post_res_valid", res_valid, 1'b0);
    check_bit("post_win_ready", win_ready, 1'b1);
    check_bit("post_err", err_timeout, exp_err);
  endtask

  initial begin
    win_t w;
    rst = 1'b0;
    host_row_valid = 1'b1; mem_write_ready = 1'b1; host_intercept_valid = 1'b1;
    win_valid = 1'b0; win_v_features = '0; win_a_features = '0;
    svm_fin_ready = 1'b1; svm_dout_valid = 1'b0; svm_valence = 1'b0; svm_arousal = 1'b0;
    res_ready = 1'b1;

    // Reset state: every output low while rst is held.
    step();
    settle();
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_row_ready", host_row_ready, 1'b0);
    check_bit("rst_we", mem_we, 1'b0);
    check_bit("rst_intercept", intercept_valid, 1'b0);
    check_val("rst_addr", 64'(mem_write_addr), 64'd0);
    check_val("rst_count", 64'(res_count), 64'd0);
    check_bit("rst_err", err_timeout, 1'b0);
    check_vec("rst_features", svm_features, '0);
    step();
    rst = 1'b1;

    // SRAM load with a five-cycle stall at row 70.
    for (int r = 0; r < ROWS; r++) begin
      if (r == 70) begin
        for (int s = 0; s < 5; s++) begin
          mem_write_ready = 1'b0; host_intercept_valid = 1'($urandom);
          settle();
          check_bit("stall_we", mem_we, 1'b0);
          check_bit("stall_row_ready", host_row_ready, 1'b0);
          check_val("stall_addr", 64'(mem_write_addr), 64'd70);
          step();
        end
      end
      mem_write_ready = 1'b1; host_intercept_valid = 1'($urandom);
      settle();
      check_bit("load_we", mem_we, 1'b1);
      check_bit("load_row_ready", host_row_ready, 1'b1);
      check_val("load_addr", 64'(mem_write_addr), 64'(r));
      check_bit("load_busy", busy, 1'b1);
      check_bit("load_done_early", mem_write_done, 1'b0);
      check_bit("load_intercept", intercept_valid, host_intercept_valid);
      step();
    end
    host_intercept_valid = 1'b1;
    settle();
    check_bit("done_pulse", mem_write_done, 1'b1);
    check_bit("done_we", mem_we, 1'b0);
    check_bit("done_intercept", intercept_valid, 1'b1);
    check_bit("done_win_ready", win_ready, 1'b0);
    check_val("done_addr_wrap", 64'(mem_write_addr), 64'd0);
    step();
    host_row_valid = 1'b0;
    settle();
    check_bit("done_gone", mem_write_done, 1'b0);
    check_bit("idle_intercept", intercept_valid, 1'b0);

    // Directed window: v = 3, a = -2, long SVM latency, backpressure both sides.
    w.v = fill_vec(9'd3); w.a = fill_vec(9'h1FE);
    w.sv = 0; w.sa = 10; w.lat = 600; w.sr = 7; w.val = 1'b1; w.aro = 1'b0;
    wins.push_back(w);
    // Minimum latency window.
    w.v = rand_vec(); w.a = rand_vec();
    w.sv = 0; w.sa = 0; w.lat = 0; w.sr = 0; w.val = 1'b0; w.aro = 1'b1;
    wins.push_back(w);
    // Randomized windows.
    for (int k = 0; k < 6; k++) begin
      w.v = rand_vec(); w.a = rand_vec();
      w.sv = $urandom_range(0, 3); w.sa = $urandom_range(0, 3);
      w.lat = $urandom_range(0, 40); w.sr = $urandom_range(0, 4);
      w.val = 1'($urandom); w.aro = 1'($urandom);
      wins.push_back(w);
    end
    // Answer on the very last allowed cycle: the result must win.
    w.v = rand_vec(); w.a = rand_vec();
    w.sv = 1; w.sa = 1; w.lat = TMO - 1; w.sr = 1; w.val = 1'b1; w.aro = 1'b1;
    wins.push_back(w);
    // No answer at all: timeout.
    w.v = rand_vec(); w.a = rand_vec();
    w.sv = 0; w.sa = 0; w.lat = -1; w.sr = 0; w.val = 1'b0; w.aro = 1'b0;
    wins.push_back(w);
    // A normal window after the timeout; the error flag stays set.
    w.v = rand_vec(); w.a = rand_vec();
    w.sv = 2; w.sa = 0; w.lat = 5; w.sr = 2; w.val = 1'b0; w.aro = 1'b1;
    wins.push_back(w);

    while (wins.size() > 0) run_window(wins.pop_front());

    // Asynchronous reset while waiting for a result.
    win_valid = 1'b1; win_v_features = rand_vec(); win_a_features = rand_vec();
    step();
    win_valid = 1'b0; svm_fin_ready = 1'b1;
    step();
    step();
    svm_fin_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    settle();
    check_bit("pre_rst_busy", busy, 1'b1);
    host_row_valid = 1'b1; mem_write_ready = 1'b1; host_intercept_valid = 1'b1;
    #1 rst = 1'b0;
    #1;
    check_bit("arst_busy", busy, 1'b0);
    check_bit("arst_res_valid", res_valid, 1'b0);
    check_bit("arst_err", err_timeout, 1'b0);
    check_val("arst_count", 64'(res_count), 64'd0);
    check_vec("arst_features", svm_features, '0);
    check_bit("arst_we", mem_we, 1'b0);
    check_bit("arst_row_ready", host_row_ready, 1'b0);
    check_bit("arst_intercept", intercept_valid, 1'b0);
    check_bit("arst_win_ready", win_ready, 1'b0);
    step();
    rst = 1'b1;
    settle();
    check_bit("reload_busy", busy, 1'b1);
    check_val("reload_addr", 64'(mem_write_addr), 64'd0);
    check_bit("reload_we", mem_we, 1'b1);
    check_bit("reload_win_ready", win_ready, 1'b0);
    step();
    settle();
    check_val("reload_addr_next", 64'(mem_write_addr), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
